// File: rtl/soc_network_adapter_ahb_frontend_pkg.sv
// Shared definitions for the network adapter AHB front end: region codes,
// front-end FSM states and the 4 KiB page bases of the adapter window.
package soc_optimsoc_configuration;

    typedef enum logic [1:0] {
        REGION_CFG,
        REGION_MPS,
        REGION_DMA,
        REGION_NONE
    } na_region_e;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_ACCESS,
        ST_ERR1,
        ST_ERR2
    } na_fe_state_e;

    localparam logic [3:0] NA_REGION_CFG = 4'h0;
    localparam logic [3:0] NA_REGION_MPS = 4'h1;
    localparam logic [3:0] NA_REGION_DMA = 4'h2;

    function automatic na_region_e na_region_decode(input logic [3:0] page);
        na_region_e r;
        case (page)
            NA_REGION_CFG: r = REGION_CFG;
            NA_REGION_MPS: r = REGION_MPS;
            NA_REGION_DMA: r = REGION_DMA;
            default:       r = REGION_NONE;
        endcase
        return r;
    endfunction

endpackage

// File: rtl/soc_network_adapter_ahb_frontend.sv
// AHB-Lite slave front end of the network adapter: decodes the 64 KiB window
// into cfg/mps/dma sub-slaves and shapes all failures into two-cycle ERRORs.
module soc_network_adapter_ahb_frontend
    import soc_optimsoc_configuration::*;
#(
    parameter int unsigned XLEN    = 32,
    parameter int unsigned TIMEOUT = 255
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            hsel,
    input  logic            hwrite,
    input  logic            hmastlock,
    input  logic [31:0]     haddr,
    input  logic [XLEN-1:0] hwdata,
    input  logic [2:0]      hsize,
    input  logic [2:0]      hburst,
    input  logic [3:0]      hprot,
    input  logic [1:0]      htrans,
    input  logic            hready,
    output logic [XLEN-1:0] hrdata,
    output logic            hreadyout,
    output logic            hresp,
    output logic            cfg_hsel,
    output logic            mps_hsel,
    output logic            dma_hsel,
    output logic [15:0]     s_haddr,
    output logic [XLEN-1:0] s_hwdata,
    output logic            s_hwrite,
    output logic [2:0]      s_hsize,
    input  logic [XLEN-1:0] cfg_hrdata,
    input  logic [XLEN-1:0] mps_hrdata,
    input  logic [XLEN-1:0] dma_hrdata,
    input  logic            cfg_hready,
    input  logic            mps_hready,
    input  logic            dma_hready,
    input  logic            cfg_hresp,
    input  logic            mps_hresp,
    input  logic            dma_hresp
);

    localparam logic [7:0] WAIT_MAX  = 8'(TIMEOUT);
    localparam logic [7:0] WAIT_LAST = 8'(TIMEOUT - 1);

    na_fe_state_e    state_q, state_d;
    na_region_e      region_q, addr_region;
    logic [7:0]      wait_cnt;
    logic            accept, take, legal;
    na_fe_state_e    accept_dest;
    logic [XLEN-1:0] sel_rdata;
    logic            sel_ready, sel_resp;

    logic unused_inputs;
    assign unused_inputs = ^{hburst, hprot, hmastlock, haddr[31:16]};

    assign s_hwdata    = hwdata;
    assign accept      = hsel & htrans[1] & hready;
    assign addr_region = na_region_decode(haddr[15:12]);
    assign legal       = (hsize <= 3'b010);
    assign accept_dest = (legal && addr_region != REGION_NONE) ? ST_ACCESS : ST_ERR1;

    always_comb begin
        sel_rdata = '0;
        sel_ready = 1'b1;
        sel_resp  = 1'b0;
        case (region_q)
            REGION_CFG: begin sel_rdata = cfg_hrdata; sel_ready = cfg_hready; sel_resp = cfg_hresp; end
            REGION_MPS: begin sel_rdata = mps_hrdata; sel_ready = mps_hready; sel_resp = mps_hresp; end
            REGION_DMA: begin sel_rdata = dma_hrdata; sel_ready = dma_hready; sel_resp = dma_hresp; end
            default: ;
        endcase
    end

    always_comb begin
        state_d   = state_q;
        take      = 1'b0;
        hreadyout = 1'b1;
        hresp     = 1'b0;
        hrdata    = '0;
        cfg_hsel  = 1'b0;
        mps_hsel  = 1'b0;
        dma_hsel  = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (accept) begin
                    take    = 1'b1;
                    state_d = accept_dest;
                end
            end
            ST_ACCESS: begin
                cfg_hsel = (region_q == REGION_CFG);
                mps_hsel = (region_q == REGION_MPS);
                dma_hsel = (region_q == REGION_DMA);
                hrdata   = s_hwrite ? '0 : sel_rdata;
                // A slave error is held off upstream so it becomes the two-cycle form.
                hreadyout = sel_ready & ~sel_resp;
                if (sel_resp) begin
                    state_d = ST_ERR1;
                end else if (sel_ready) begin
                    if (accept) begin
                        take    = 1'b1;
                        state_d = accept_dest;
                    end else begin
                        state_d = ST_IDLE;
                    end
                end else if (wait_cnt >= WAIT_LAST) begin
                    state_d = ST_ERR1;
                end
            end
            ST_ERR1: begin
                hreadyout = 1'b0;
                hresp     = 1'b1;
                state_d   = ST_ERR2;
            end
            ST_ERR2: begin
                hresp = 1'b1;
                if (accept) begin
                    take    = 1'b1;
                    state_d = accept_dest;
                end else begin
                    state_d = ST_IDLE;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q  <= ST_IDLE;
            region_q <= REGION_NONE;
            s_haddr  <= '0;
            s_hwrite <= 1'b0;
            s_hsize  <= '0;
            wait_cnt <= '0;
        end else begin
            state_q <= state_d;
            if (take) begin
                region_q <= addr_region;
                s_haddr  <= haddr[15:0];
                s_hwrite <= hwrite;
                s_hsize  <= hsize;
                wait_cnt <= '0;
            end else if (state_q == ST_ACCESS && !sel_ready && !sel_resp && wait_cnt != WAIT_MAX) begin
                wait_cnt <= wait_cnt + 8'd1;
            end
        end
    end

endmodule

// File: tb/tb_soc_network_adapter_ahb_frontend.sv
// Table-driven bench for the adapter AHB front end (TIMEOUT = 4), with a
// hand-written reset-during-wait sequence.
module tb_soc_network_adapter_ahb_frontend;

    localparam logic [31:0] CFG_DATA = 32'h0000_0005;
    localparam logic [31:0] MPS_DATA = 32'h1111_0000;
    localparam logic [31:0] DMA_DATA = 32'hDDDD_0001;
    localparam logic [5:0]  OK       = 6'b101010;

    logic        clk = 1'b0;
    logic        rst;
    logic        hsel, hwrite, hmastlock;
    logic [31:0] haddr, hwdata, hrdata;
    logic [2:0]  hsize, hburst;
    logic [3:0]  hprot;
    logic [1:0]  htrans;
    logic        hready, hreadyout, hresp;
    logic        cfg_hsel, mps_hsel, dma_hsel;
    logic [15:0] s_haddr;
    logic [31:0] s_hwdata;
    logic        s_hwrite;
    logic [2:0]  s_hsize;
    logic        cfg_hready, mps_hready, dma_hready;
    logic        cfg_hresp, mps_hresp, dma_hresp;

    int checks   = 0;
    int failures = 0;

    always #5 clk = ~clk;
    assign hready = hreadyout;

    soc_network_adapter_ahb_frontend #(.XLEN(32), .TIMEOUT(4)) dut (
        .clk(clk), .rst(rst), .hsel(hsel), .hwrite(hwrite), .hmastlock(hmastlock),
        .haddr(haddr), .hwdata(hwdata), .hsize(hsize), .hburst(hburst), .hprot(hprot),
        .htrans(htrans), .hready(hready), .hrdata(hrdata), .hreadyout(hreadyout),
        .hresp(hresp), .cfg_hsel(cfg_hsel), .mps_hsel(mps_hsel), .dma_hsel(dma_hsel),
        .s_haddr(s_haddr), .s_hwdata(s_hwdata), .s_hwrite(s_hwrite), .s_hsize(s_hsize),
        .cfg_hrdata(CFG_DATA), .mps_hrdata(MPS_DATA), .dma_hrdata(DMA_DATA),
        .cfg_hready(cfg_hready), .mps_hready(mps_hready), .dma_hready(dma_hready),
        .cfg_hresp(cfg_hresp), .mps_hresp(mps_hresp), .dma_hresp(dma_hresp)
    );

    // slv = {cfg_rdy, cfg_resp, mps_rdy, mps_resp, dma_rdy, dma_resp}
    // e_ctl = {hreadyout, hresp, cfg_hsel, mps_hsel, dma_hsel, s_hwrite}
    typedef struct {
        logic        hsel;
        logic [1:0]  htrans;
        logic        hwrite;
        logic [31:0] haddr;
        logic [2:0]  hsize;
        logic [31:0] hwdata;
        logic [5:0]  slv;
        logic [5:0]  e_ctl;
        logic [31:0] e_rdata;
        logic [15:0] e_saddr;
    } vec_t;

    vec_t vecs[23];

    function automatic vec_t mk(input logic s, input logic [1:0] t, input logic w,
                                input logic [31:0] a, input logic [2:0] sz, input logic [31:0] wd,
                                input logic [5:0] sl, input logic [5:0] c, input logic [31:0] rd,
                                input logic [15:0] sa);
        vec_t v;
        v.hsel = s; v.htrans = t; v.hwrite = w; v.haddr = a; v.hsize = sz; v.hwdata = wd;
        v.slv = sl; v.e_ctl = c; v.e_rdata = rd; v.e_saddr = sa;
        return v;
    endfunction

    task automatic check(input string nm, input int idx, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s step %0d: got %h expected %h", nm, idx, act, exp);
        end
    endtask

    task automatic drive(input logic s, input logic [1:0] t, input logic w, input logic [31:0] a,
                         input logic [2:0] sz, input logic [31:0] wd, input logic [5:0] sl);
        hsel = s; htrans = t; hwrite = w; haddr = a; hsize = sz; hwdata = wd;
        {cfg_hready, cfg_hresp, mps_hready, mps_hresp, dma_hready, dma_hresp} = sl;
    endtask

    task automatic check_all(input int idx, input logic [5:0] c, input logic [31:0] rd, input logic [15:0] sa);
        check("ctl", idx, 32'({hreadyout, hresp, cfg_hsel, mps_hsel, dma_hsel, s_hwrite}), 32'(c));
        check("hrdata", idx, hrdata, rd);
        check("s_haddr", idx, 32'(s_haddr), 32'(sa));
    endtask

    initial begin
        vecs[0]  = mk(0, 2'd0, 0, 32'h0,         3'd2, 32'h0,         OK,        6'b100000, 32'h0,   16'h0000);
        vecs[1]  = mk(1, 2'd2, 0, 32'h4A00_0000, 3'd2, 32'h0,         OK,        6'b100000, 32'h0,   16'h0000);
        vecs[2]  = mk(1, 2'd2, 0, 32'h0000_1000, 3'd2, 32'h0,         OK,        6'b101000, CFG_DATA, 16'h0000);
        vecs[3]  = mk(1, 2'd2, 0, 32'h0000_2004, 3'd2, 32'h0,         OK,        6'b100100, MPS_DATA, 16'h1000);
        vecs[4]  = mk(1, 2'd2, 1, 32'h0000_4000, 3'd2, 32'h0,         OK,        6'b100010, DMA_DATA, 16'h2004);
        vecs[5]  = mk(0, 2'd0, 0, 32'h0,         3'd2, 32'h0000_CAFE, OK,        6'b010001, 32'h0,   16'h4000);
        vecs[6]  = mk(0, 2'd0, 0, 32'h0,         3'd2, 32'h0,         OK,        6'b110001, 32'h0,   16'h4000);
        vecs[7]  = mk(1, 2'd2, 1, 32'h0000_0010, 3'd2, 32'h0,         OK,        6'b100001, 32'h0,   16'h4000);
        vecs[8]  = mk(1, 2'd2, 0, 32'h0000_0000, 3'd3, 32'h1234_5678, OK,        6'b101001, 32'h0,   16'h0010);
        vecs[9]  = mk(0, 2'd0, 0, 32'h0,         3'd2, 32'h0,         OK,        6'b010000, 32'h0,   16'h0000);
        vecs[10] = mk(1, 2'd2, 0, 32'h0000_0004, 3'd2, 32'h0,         OK,        6'b110000, 32'h0,   16'h0000);
        vecs[11] = mk(0, 2'd0, 0, 32'h0,         3'd2, 32'h0,         6'b011010, 6'b001000, CFG_DATA, 16'h0004);
        vecs[12] = mk(0, 2'd0, 0, 32'h0,         3'd2, 32'h0,         OK,        6'b010000, 32'h0,   16'h0004);
        vecs[13] = mk(1, 2'd2, 0, 32'h0000_2000, 3'd2, 32'h0,         OK,        6'b110000, 32'h0,   16'h0004);
        vecs[14] = mk(0, 2'd0, 0, 32'h0,         3'd2, 32'h0,         6'b101000, 6'b000010, DMA_DATA, 16'h2000);
        vecs[15] = mk(0, 2'd0, 0, 32'h0,         3'd2, 32'h0,         6'b101000, 6'b000010, DMA_DATA, 16'h2000);
        vecs[16] = mk(0, 2'd0, 0, 32'h0,         3'd2, 32'h0,         6'b101000, 6'b000010, DMA_DATA, 16'h2000);
        vecs[17] = mk(0, 2'd0, 0, 32'h0,         3'd2, 32'h0,         6'b101000, 6'b000010, DMA_DATA, 16'h2000);
        vecs[18] = mk(0, 2'd0, 0, 32'h0,         3'd2, 32'h0,         6'b101000, 6'b010000, 32'h0,   16'h2000);
        vecs[19] = mk(0, 2'd0, 0, 32'h0,         3'd2, 32'h0,         OK,        6'b110000, 32'h0,   16'h2000);
        vecs[20] = mk(1, 2'd1, 0, 32'h0000_1000, 3'd2, 32'h0,         OK,        6'b100000, 32'h0,   16'h2000);
        vecs[21] = mk(1, 2'd0, 0, 32'h0000_1000, 3'd2, 32'h0,         OK,        6'b100000, 32'h0,   16'h2000);
        vecs[22] = mk(0, 2'd0, 0, 32'h0,         3'd2, 32'h0,         OK,        6'b100000, 32'h0,   16'h2000);

        hmastlock = 1'b0; hburst = 3'd0; hprot = 4'h3;
        drive(0, 2'd0, 0, 32'h0, 3'd0, 32'h0, OK);
        rst = 1'b1;
        repeat (2) @(posedge clk);
        #1 rst = 1'b0;
        #4;
        check_all(-1, 6'b100000, 32'h0, 16'h0000);
        check("s_hsize", -1, 32'(s_hsize), 32'd0);

        for (int i = 0; i < 23; i++) begin
            @(posedge clk);
            #1 drive(vecs[i].hsel, vecs[i].htrans, vecs[i].hwrite, vecs[i].haddr,
                     vecs[i].hsize, vecs[i].hwdata, vecs[i].slv);
            #4;
            check_all(i, vecs[i].e_ctl, vecs[i].e_rdata, vecs[i].e_saddr);
            check("s_hwdata", i, s_hwdata, vecs[i].hwdata);
            if (i == 9) check("s_hsize", i, 32'(s_hsize), 32'd3);
        end

        // Reset pulse while mps is stalling: the data phase is dropped next cycle.
        @(posedge clk);
        #1 drive(1, 2'd2, 0, 32'h0000_1000, 3'd1, 32'h0, 6'b100010);
        #4 check_all(100, 6'b100000, 32'h0, 16'h2000);
        @(posedge clk);
        #1 begin drive(0, 2'd0, 0, 32'h0, 3'd0, 32'h0, 6'b100010); rst = 1'b1; end
        #4 check_all(101, 6'b000100, MPS_DATA, 16'h1000);
        check("s_hsize", 101, 32'(s_hsize), 32'd1);
        @(posedge clk);
        #1 rst = 1'b0;
        #4 check_all(102, 6'b100000, 32'h0, 16'h0000);
        check("s_hsize", 102, 32'(s_hsize), 32'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/soc_network_adapter_ahb_frontend.md
# soc_network_adapter_ahb_frontend

AHB-Lite slave front end of the network adapter: accepts transfers from the tile bus, registers the address phase, decodes the 64 KiB adapter window into its sub-slaves (configuration registers, mp_simple, DMA), and drives each sub-slave's data phase. It collects sub-slave responses and returns them upstream. It converts sub-slave error flags, unmapped accesses, illegal sizes and stalled sub-slaves into protocol-correct two-cycle AHB ERROR responses. It sits directly upstream of the configuration register block and its siblings.

## Interface
- XLEN, 32: data width.
- TIMEOUT, 255: maximum sub-slave wait cycles before a forced ERROR; 1..255, 8-bit counter.
- clk  in  1  clock.
- rst  in  1  reset: rst, synchronous, active-high; clock clk.
- hsel, hwrite, hmastlock  in  1  upstream AHB-Lite controls.
- haddr  in  32  upstream address; only [15:0] is used.
- hwdata  in  XLEN  upstream write data, valid in the data phase.
- hsize, hburst  in  3  each; hprot  in  4; htrans  in  2.
- hready  in  1  upstream HREADY (hreadyin).
- hrdata  out  XLEN  read data.
- hreadyout  out  1  upstream ready.
- hresp  out  1  upstream error response.
- cfg_hsel, mps_hsel, dma_hsel  out  1  one-hot sub-slave selects, asserted in the data phase.
- s_haddr  out  16  registered local address.
- s_hwdata  out  XLEN  pass-through of hwdata.
- s_hwrite  out  1  registered write flag.
- s_hsize  out  3  registered transfer size.
- cfg_/mps_/dma_hrdata  in  XLEN  sub-slave read data.
- cfg_/mps_/dma_hready  in  1  sub-slave ready.
- cfg_/mps_/dma_hresp  in  1  sub-slave error flag.

## Operation
- **Accept** when hsel & htrans[1] & hready. IDLE/BUSY transfers get a zero-wait OKAY response.
- **Region decode** on haddr[15:12]:
  - 0x0: cfg.
  - 0x1: mps.
  - 0x2: dma.
  - other: unmapped.
  - hsize > 3'b010 is illegal.
- **Address-phase registers**, loaded on accept: region, haddr[15:0], hwrite, hsize.
- **FSM states**:
  - IDLE: no data phase pending.
  - ACCESS: sub-slave data phase.
  - ERR1, ERR2: the two cycles of the ERROR response.
- **IDLE transitions**: accept of a legal, mapped transfer -> ACCESS; accept of an unmapped or illegal transfer -> ERR1; no accept -> stay in IDLE.
- **ACCESS behaviour**:
  - Selected *_hsel = 1.
  - hrdata = the selected slave's hrdata on reads, 0 on writes.
  - hreadyout = the selected slave's hready.
  - hresp = 0.
- **ACCESS transitions**:
  - Selected slave hresp = 1 -> ERR1.
  - Slave hready = 1 & hresp = 0 -> completes. The same cycle may accept the next transfer: -> ACCESS or ERR1 per decode, otherwise -> IDLE.
  - Slave hready = 0 -> wait; the wait counter increments. The counter reaching TIMEOUT -> ERR1.
- **ERR1**: hreadyout = 0, hresp = 1, all *_hsel = 0 -> ERR2.
- **ERR2**:
  - hreadyout = 1, hresp = 1.
  - A transfer presented in this cycle is accepted normally, since upstream hready = 1.
  - -> ACCESS, ERR1 or IDLE.
- **Wait counter**: 8 bits, cleared on every accept, saturates at TIMEOUT.
- **Ignored inputs**: hburst, hprot and hmastlock are accepted but ignored; every beat is treated as an independent single transfer.

## Timing
- **Reset values**:
  - State IDLE.
  - hreadyout = 1, hresp = 0, hrdata = 0.
  - All *_hsel = 0.
  - s_haddr = 0, s_hwrite = 0, s_hsize = 0.
  - Wait counter = 0.
- **Reset mid-transfer**: the pending data phase is abandoned with no sub-slave select in the following cycle.
- **Latency**: address phase in cycle N; sub-slave select and address in cycle N+1. A combinational sub-slave (cfg) completes in N+1 with zero upstream wait states.
- **Write data**: s_hwdata is combinational from hwdata, valid in cycle N+1.
- **Address hold during waits**: while hreadyout = 0, upstream address-phase signals are not sampled. The master holds them per AHB.
- **Back-to-back**: transfers sustain one per cycle to zero-wait slaves.
- **ERROR timing**: always exactly 2 cycles. A sub-slave single-cycle hresp is stretched into that form.
- **Unmapped accesses**: never assert any *_hsel.

## Structure
- **Shared package** (soc_optimsoc_configuration): region code enum (CFG, MPS, DMA, NONE), FSM state enum, NA_REGION_* base constants.
- **Decode**: a package function na_region_decode(haddr[15:12]) returns the region code.
- **Sub-modules**: none; a single module.

## Test plan
- **Config read**: read 0x0000 with cfg_hrdata = 0x5 -> cfg_hsel = 1 in N+1, hrdata = 0x5, hreadyout = 1, hresp = 0, zero waits.
- **Back-to-back**: reads 0x1000 then 0x2004 back-to-back -> mps_hsel in N+1, dma_hsel in N+2, s_haddr = 0x1000 then 0x2004.
- **Unmapped write**: write to 0x4000 -> no *_hsel; then hreadyout/hresp = 0/1, then 1/1; state returns to IDLE.
- **Stretched error**: cfg_hready = 0 with cfg_hresp = 1 for one cycle -> two-cycle ERROR; the next transfer is accepted in ERR2.
- **Timeout**: TIMEOUT = 4, dma_hready held 0 -> 4 wait cycles, then ERROR, dma_hsel dropped.
- **Mid-transfer reset**: rst pulse during an mps wait -> next cycle mps_hsel = 0, hreadyout = 1, hresp = 0.
